// File: rtl/mdu_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_ctrl
// Purpose  : Multi-cycle DIV/DIVU controller and datapath. This is a radix-2
//            restoring divider that runs 32 iterations. It sits beside the EX
//            stage and stalls the pipeline until the result is ready. It then
//            presents {remainder, quotient} in HI/LO layout to MEM.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   system clock
//   rst        in   1   asynchronous reset, active-high
//   start      in   1   level: DIV/DIVU valid in EX
//   sign       in   1   1 = DIV (signed), 0 = DIVU
//   opa        in  32   dividend (rs)
//   opb        in  32   divisor (rt)
//   flush      in   1   pipeline flush, aborts any divide
//   hold       in   1   downstream stall, pipeline cannot advance
//   stall_o    out  1   EX stall request (combinational)
//   res_valid  out  1   divres valid this cycle
//   divres     out 64   {remainder[63:32], quotient[31:0]}
// ============================================================================
module mdu_div_ctrl #(
    parameter logic [31:0] DIVZ_QUOT = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        flush,
    input  logic        hold,
    output logic        stall_o,
    output logic        res_valid,
    output logic [63:0] divres
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DZERO = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] c_LAST_ITER = 5'd31;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [4:0]  r_cnt;
    logic [31:0] r_rem;      // partial remainder
    logic [31:0] r_quot;     // dividend bits shift out as quotient bits shift in
    logic [31:0] r_dmag;     // divisor magnitude
    logic [31:0] r_opa;      // raw dividend, reported as remainder on divide-by-zero
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] r_divres;

    logic        w_latch;
    logic        w_iter;
    logic        w_last;
    logic [31:0] w_amag;
    logic [31:0] w_bmag;
    logic [32:0] w_trial;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quot_nxt;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    // ------------------------------------------------------------------
    // Qualifiers
    // ------------------------------------------------------------------
    assign w_latch = (r_state == ST_IDLE) && start && !flush;
    assign w_iter  = (r_state == ST_RUN) && !flush;
    assign w_last  = w_iter && (r_cnt == c_LAST_ITER);

    // Operand magnitudes. These are used only when the operation is signed.
    assign w_amag = (sign && opa[31]) ? (32'd0 - opa) : opa;
    assign w_bmag = (sign && opb[31]) ? (32'd0 - opb) : opb;

    // ------------------------------------------------------------------
    // One restoring iteration. The shifted partial remainder needs 33 bits.
    // It is always below twice the divisor, so a 33-bit difference keeps a
    // valid sign bit.
    // ------------------------------------------------------------------
    always_comb begin
        w_trial    = {r_rem, r_quot[31]} - {1'b0, r_dmag};
        w_rem_nxt  = {r_rem[30:0], r_quot[31]};
        w_quot_nxt = {r_quot[30:0], 1'b0};
        if (!w_trial[32]) begin
            w_rem_nxt  = w_trial[31:0];
            w_quot_nxt = {r_quot[30:0], 1'b1};
        end
    end

    // Sign fix applied to the final iteration's outputs. For 0x8000_0000 / -1,
    // neg_q is 0 and the magnitude quotient 0x8000_0000 passes through
    // unchanged.
    assign w_q_fix = r_neg_q ? (32'd0 - w_quot_nxt) : w_quot_nxt;
    assign w_r_fix = r_neg_r ? (32'd0 - w_rem_nxt)  : w_rem_nxt;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state. Flush overrides start and hold from every state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = (opb == 32'd0) ? ST_DZERO : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == c_LAST_ITER) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DZERO: begin
                    w_state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    if (!hold) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 5'd0;
            r_rem    <= 32'd0;
            r_quot   <= 32'd0;
            r_dmag   <= 32'd0;
            r_opa    <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_divres <= 64'd0;
        end else begin
            if (w_latch) begin
                r_cnt   <= 5'd0;
                r_rem   <= 32'd0;
                r_quot  <= w_amag;
                r_dmag  <= w_bmag;
                r_opa   <= opa;
                r_neg_q <= sign && (opa[31] ^ opb[31]);
                r_neg_r <= sign && opa[31];
            end else if (w_iter) begin
                r_cnt  <= r_cnt + 5'd1;
                r_rem  <= w_rem_nxt;
                r_quot <= w_quot_nxt;
            end

            // divres changes only when a result is produced. An aborted divide
            // leaves the previous result in place.
            if (w_last) begin
                r_divres <= {w_r_fix, w_q_fix};
            end else if ((r_state == ST_DZERO) && !flush) begin
                r_divres <= {r_opa, DIVZ_QUOT};
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // stall_o is gated by rst so that it stays low for the whole reset.
    // This holds even when start is high during reset.
    assign stall_o   = !rst && !flush &&
                       (((r_state == ST_IDLE) && start) ||
                        (r_state == ST_RUN) ||
                        (r_state == ST_DZERO));
    assign res_valid = (r_state == ST_DONE);
    assign divres    = r_divres;

endmodule
`default_nettype wire

// File: tb/tb_mdu_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_div_ctrl
// Purpose  : Directed self-checking bench for mdu_div_ctrl. The vectors use
//            hand-computed results. Cycle 0 of each divide is the cycle in
//            which start is first presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        hold;
    logic        stall_o;
    logic        res_valid;
    logic [63:0] divres;

    int n_checks;
    int n_errors;

    mdu_div_ctrl #(
        .DIVZ_QUOT (32'hFFFF_FFFF)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign      (sign),
        .opa       (opa),
        .opb       (opb),
        .flush     (flush),
        .hold      (hold),
        .stall_o   (stall_o),
        .res_valid (res_valid),
        .divres    (divres)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge. Outputs are sampled
    // 1 unit after that.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one divide with start held high until the result cycle. The
    // operands are corrupted after cycle 0 so that the bench checks they
    // are latched. hold is asserted for n_hold cycles starting at the
    // result cycle.
    task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int n_hold);
        int lat;
        lat = (b == 32'd0) ? 2 : 33;
        for (int c = 0; c <= lat + n_hold; c++) begin
            start = 1'b1;
            sign  = (c == 0) ? s : ~s;
            opa   = (c == 0) ? a : ~a;
            opb   = (c == 0) ? b : (b ^ 32'h5A5A_0001);
            hold  = (c >= lat) && (c < lat + n_hold);
            #1;
            chk({tag, " stall"}, 64'(stall_o), 64'(c < lat));
            chk({tag, " valid"}, 64'(res_valid), 64'(c >= lat));
            if (c >= lat) begin
                chk({tag, " divres"}, divres, exp);
            end
            step();
        end
        start = 1'b0;
        hold  = 1'b0;
        #1;
        chk({tag, " idle valid"}, 64'(res_valid), 64'd0);
        chk({tag, " idle stall"}, 64'(stall_o), 64'd0);
        chk({tag, " idle divres"}, divres, exp);
        step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        start = 1'b1;
        sign  = 1'b0;
        opa   = 32'd100;
        opb   = 32'd7;
        flush = 1'b0;
        hold  = 1'b0;
        step();
        step();
        chk("reset stall", 64'(stall_o), 64'd0);
        chk("reset valid", 64'(res_valid), 64'd0);
        chk("reset divres", divres, 64'd0);
        start = 1'b0;
        rst   = 1'b0;
        step();

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 0);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 0);
        do_div("divu_8k_3", 1'b0, 32'h8000_0000, 32'd3, {32'd2, 32'h2AAA_AAAA}, 0);
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 0);
        do_div("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 0);
        // hold in cycles 33-34 keeps res_valid high through cycle 35, and the
        // block returns to IDLE in cycle 36.
        do_div("divu_hold", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 2);

        // Flush in cycle 10 of a divide.
        for (int c = 0; c <= 10; c++) begin
            start = 1'b1;
            sign  = 1'b0;
            opa   = 32'd100;
            opb   = 32'd7;
            flush = (c == 10);
            #1;
            if (c == 10) begin
                chk("flush stall", 64'(stall_o), 64'd0);
            end else begin
                chk("preflush stall", 64'(stall_o), 64'd1);
            end
            chk("flush valid", 64'(res_valid), 64'd0);
            step();
        end
        start = 1'b0;
        flush = 1'b0;
        #1;
        chk("postflush valid", 64'(res_valid), 64'd0);
        chk("postflush stall", 64'(stall_o), 64'd0);
        chk("postflush divres", divres, {32'd2, 32'd14});
        step();
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);

        // Asynchronous reset in cycle 15 of a divide.
        for (int c = 0; c < 15; c++) begin
            start = 1'b1;
            sign  = 1'b0;
            opa   = 32'd100;
            opb   = 32'd7;
            #1;
            chk("prerst stall", 64'(stall_o), 64'd1);
            step();
        end
        rst = 1'b1;
        #1;
        chk("rst stall", 64'(stall_o), 64'd0);
        chk("rst valid", 64'(res_valid), 64'd0);
        chk("rst divres", divres, 64'd0);
        step();
        chk("rst held stall", 64'(stall_o), 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        #1;
        chk("postrst valid", 64'(res_valid), 64'd0);
        chk("postrst stall", 64'(stall_o), 64'd0);
        step();
        do_div("divu_9_3_post", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
